// File: rtl/regfile_write_sequencer_if.sv
// Retire-side handshake and register-file write port of the write-back sequencer.
interface regfile_write_sequencer_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          reg_write;
  logic          reg_write2;
  logic          jr;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic [AW-1:0] wa2;
  logic [DW-1:0] wd2;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          wb_done;
  logic          busy;

  modport master (
    output in_valid, reg_write, reg_write2, jr, wa1, wd1, wa2, wd2,
    input  in_ready, rf_we, rf_wa, rf_wd, wb_done, busy
  );

  modport slave (
    input  in_valid, reg_write, reg_write2, jr, wa1, wd1, wa2, wd2,
    output in_ready, rf_we, rf_wa, rf_wd, wb_done, busy
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Serialises one or two register writes per retiring instruction onto a single RF write port.
module regfile_write_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic                                   clk,
  input logic                                   reset,
  regfile_write_sequencer_if.slave              bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] W1   = 2'd1;
  localparam logic [1:0] W2   = 2'd2;
  localparam logic [1:0] NOP  = 2'd3;

  typedef struct packed {
    logic          w2;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd2;
  } req_t;

  logic [1:0] state, state_nxt;
  req_t       req;
  logic       w1_in, w2_in, accept;

  assign w1_in  = bus.reg_write  & ~bus.jr;
  assign w2_in  = bus.reg_write2 & ~bus.jr;

  // Only a W1 with its second write still owed blocks the upstream stage.
  assign bus.in_ready = (state != W1) | ~req.w2;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nxt = IDLE;
    if (accept)
      state_nxt = w1_in ? W1 : (w2_in ? W2 : NOP);
    else if (state == W1 && req.w2)
      state_nxt = W2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        req <= '{w2: w2_in, wa1: bus.wa1, wd1: bus.wd1, wa2: bus.wa2, wd2: bus.wd2};
    end
  end

  // Outputs decode from state and captured request only; a new capture lands after the edge.
  always_comb begin
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    case (state)
      W1: begin bus.rf_wa = req.wa1; bus.rf_wd = req.wd1; end
      W2: begin bus.rf_wa = req.wa2; bus.rf_wd = req.wd2; end
      default: ;
    endcase
  end

  // $zero writes are dropped but still occupy their slot.
  assign bus.rf_we   = ((state == W1) && (req.wa1 != '0)) | ((state == W2) && (req.wa2 != '0));
  assign bus.wb_done = (state == NOP) | (state == W2) | ((state == W1) & ~req.w2);
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: per-cycle compare against a write-slot queue model.
module tb_regfile_write_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_write_sequencer_if #(.DW(32), .AW(5)) bus();

  regfile_write_sequencer #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: each accepted instruction becomes a list of output cycles; the queue front is this cycle.
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        done;
  } slot_t;

  slot_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      logic acc, w1, w2;
      acc = bus.in_valid && (q.size() <= 1);
      w1  = bus.reg_write  && !bus.jr;
      w2  = bus.reg_write2 && !bus.jr;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        if (w1) q.push_back('{bus.wa1 != 0, bus.wa1, bus.wd1, !w2});
        if (w2) q.push_back('{bus.wa2 != 0, bus.wa2, bus.wd2, 1'b1});
        if (!w1 && !w2) q.push_back('{1'b0, 5'd0, 32'd0, 1'b1});
      end
    end
  end

  always @(negedge clk) begin
    slot_t e;
    e = '{1'b0, 5'd0, 32'd0, 1'b0};
    if (q.size() > 0) e = q[0];
    chk("cyc_rf_we",    {31'd0, bus.rf_we},    {31'd0, e.we});
    chk("cyc_rf_wa",    {27'd0, bus.rf_wa},    {27'd0, e.wa});
    chk("cyc_rf_wd",    bus.rf_wd,             e.wd);
    chk("cyc_wb_done",  {31'd0, bus.wb_done},  {31'd0, e.done});
    chk("cyc_busy",     {31'd0, bus.busy},     {31'd0, q.size() > 0});
    chk("cyc_in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() <= 1});
  end

  task automatic drive(input logic v, input logic rw, input logic rw2, input logic j,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
    bus.in_valid = v; bus.reg_write = rw; bus.reg_write2 = rw2; bus.jr = j;
    bus.wa1 = a1; bus.wd1 = d1; bus.wa2 = a2; bus.wd2 = d2;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    #12 reset = 1'b0;
    step();

    // Single write to r8
    drive(1, 1, 0, 0, 5'd8, 32'hDEADBEEF, 5'd0, 32'd0);
    step();
    chk("w8_we", {31'd0, bus.rf_we}, 32'd1);
    chk("w8_wa", {27'd0, bus.rf_wa}, 32'd8);
    chk("w8_wd", bus.rf_wd, 32'hDEADBEEF);
    chk("w8_done", {31'd0, bus.wb_done}, 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("w8_idle_we", {31'd0, bus.rf_we}, 32'd0);
    chk("w8_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Dual write with in_valid held through the blocked cycle
    drive(1, 1, 1, 0, 5'd9, 32'h1, 5'd10, 32'h2);
    step();
    chk("dual_first_wa", {27'd0, bus.rf_wa}, 32'd9);
    chk("dual_first_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("dual_first_done", {31'd0, bus.wb_done}, 32'd0);
    step();
    chk("dual_second_wa", {27'd0, bus.rf_wa}, 32'd10);
    chk("dual_second_wd", bus.rf_wd, 32'h2);
    chk("dual_second_done", {31'd0, bus.wb_done}, 32'd1);
    chk("dual_second_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    step();

    // jr overrides both write requests
    drive(1, 1, 1, 1, 5'd4, 32'h44, 5'd5, 32'h55);
    step();
    chk("jr_we", {31'd0, bus.rf_we}, 32'd0);
    chk("jr_done", {31'd0, bus.wb_done}, 32'd1);
    chk("jr_ready", {31'd0, bus.in_ready}, 32'd1);

    // $zero write suppressed, back-to-back after the NOP
    drive(1, 1, 0, 0, 5'd0, 32'h77, 5'd0, 32'd0);
    step();
    chk("zero_we", {31'd0, bus.rf_we}, 32'd0);
    chk("zero_done", {31'd0, bus.wb_done}, 32'd1);

    // Back-to-back single writes 1,2,3
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 0, 5'(i), 32'h100 + 32'(i), 5'd0, 32'd0);
      step();
      chk("b2b_we", {31'd0, bus.rf_we}, 32'd1);
      chk("b2b_wa", {27'd0, bus.rf_wa}, 32'(i));
    end

    // Only second write requested
    drive(1, 0, 1, 0, 5'd7, 32'h7, 5'd11, 32'hB);
    step();
    chk("w2only_wa", {27'd0, bus.rf_wa}, 32'd11);
    chk("w2only_done", {31'd0, bus.wb_done}, 32'd1);

    // Dual, then a held single that must be taken in the W2 cycle without a bubble
    drive(1, 1, 1, 0, 5'd20, 32'hA0, 5'd21, 32'hA1);
    step();
    drive(1, 1, 0, 0, 5'd14, 32'hE, 5'd0, 32'd0);
    step();
    chk("held_w2_wa", {27'd0, bus.rf_wa}, 32'd21);
    step();
    chk("held_single_wa", {27'd0, bus.rf_wa}, 32'd14);
    chk("held_single_we", {31'd0, bus.rf_we}, 32'd1);

    // Dual with second destination $zero
    drive(1, 1, 1, 0, 5'd6, 32'h6, 5'd0, 32'h9);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("dual_zero2_we", {31'd0, bus.rf_we}, 32'd0);
    chk("dual_zero2_done", {31'd0, bus.wb_done}, 32'd1);
    step();

    // Reset in the middle of W1 drops the pending second write
    drive(1, 1, 1, 0, 5'd12, 32'hC, 5'd13, 32'hD);
    step();
    bus.in_valid = 1'b0;
    chk("prerst_wa", {27'd0, bus.rf_wa}, 32'd12);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_async_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
    #4 reset = 1'b0;
    step();
    chk("postrst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("postrst_wa", {27'd0, bus.rf_wa}, 32'd0);

    // First acceptance right after reset
    drive(1, 1, 0, 0, 5'd31, 32'hFFFF0000, 5'd0, 32'd0);
    step();
    chk("postrst_first_wa", {27'd0, bus.rf_wa}, 32'd31);
    bus.in_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
